dest_output_arbiter: RTL and testbench

Downstream drain stage of `full_logic`. Pops the two destination FIFOs (D0, D1) round-robin and merges their words into one valid/ready output stream tagged with the source destination, through a 2-entry output buffer. Keeps per-destination delivered-word counters for link statistics.

---
 rtl/dest_output_arbiter_if.sv | 35 +++
 rtl/dest_output_arbiter.sv | 120 ++++++++++++
 tb/tb_dest_output_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_output_arbiter_if.sv
// rtl/dest_output_arbiter_if.sv - D-FIFO read side and merged output stream of dest_output_arbiter
//
// slave  : arbiter side (reads FIFO flags/data and out_ready, drives pops and the output word)
// master : environment side (FIFOs plus downstream sink)
//   empty_fifo_D0/D1  FIFO empty flags
//   data_out_D0/D1    FIFO read data, valid the cycle after a pop
//   D0_pop/D1_pop     pop strobes
//   out_ready         sink accepts data_out this cycle
//   valid_out         data_out/dest_out hold a word
//   data_out          head-of-buffer word
//   dest_out          source FIFO of the head word (0 = D0, 1 = D1)
interface dest_output_arbiter_if #(
    parameter int data_width = 6
);
    logic                  empty_fifo_D0;
    logic                  empty_fifo_D1;
    logic [data_width-1:0] data_out_D0;
    logic [data_width-1:0] data_out_D1;
    logic                  D0_pop;
    logic                  D1_pop;
    logic                  out_ready;
    logic                  valid_out;
    logic [data_width-1:0] data_out;
    logic                  dest_out;

    modport slave (
        input  empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
        output D0_pop, D1_pop, valid_out, data_out, dest_out
    );

    modport master (
        output empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
        input  D0_pop, D1_pop, valid_out, data_out, dest_out
    );
endinterface

// File: rtl/dest_output_arbiter.sv
// rtl/dest_output_arbiter.sv - round-robin drain of D0/D1 FIFOs into one tagged valid/ready stream
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   active_in  new pops allowed only while 1
//   bus        dest_output_arbiter_if.slave (FIFO flags/data/pops, output stream)
//   cnt_D0/D1  wrapping per-destination delivered-word counters
module dest_output_arbiter #(
    parameter int data_width = 6,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active_in,
    dest_output_arbiter_if.slave bus,
    output logic [cnt_width-1:0] cnt_D0,
    output logic [cnt_width-1:0] cnt_D1
);
    logic                  inflight;
    logic                  inflight_dest;
    logic                  last_grant;
    logic [1:0]            count;
    logic [data_width-1:0] head_data;
    logic [data_width-1:0] tail_data;
    logic                  head_dest;
    logic                  tail_dest;

    logic                  drain;
    logic                  room;
    logic                  both_ready;
    logic                  any_ready;
    logic                  grant;
    logic                  pop_en;
    logic [1:0]            count_drained;
    logic [1:0]            count_nxt;
    logic [data_width-1:0] push_data;
    logic [data_width-1:0] head_data_nxt;
    logic [data_width-1:0] tail_data_nxt;
    logic                  head_dest_nxt;
    logic                  tail_dest_nxt;

    assign drain         = (count != 2'd0) && bus.out_ready;
    assign count_drained = count - {1'b0, drain};
    // count + inflight never exceeds 2, so this sum fits in two bits.
    // A new pop is only safe if at most one word is still owed a slot after this edge.
    assign room          = ((count_drained + {1'b0, inflight}) <= 2'd1);

    assign both_ready = !bus.empty_fifo_D0 && !bus.empty_fifo_D1;
    assign any_ready  = !bus.empty_fifo_D0 || !bus.empty_fifo_D1;
    // With a single non-empty FIFO, empty_fifo_D0 directly names the winner.
    assign grant      = both_ready ? ~last_grant : bus.empty_fifo_D0;
    assign pop_en     = reset && active_in && room && any_ready;

    assign bus.D0_pop = pop_en && !grant;
    assign bus.D1_pop = pop_en && grant;

    assign push_data = inflight_dest ? bus.data_out_D1 : bus.data_out_D0;

    // Head/tail two-slot buffer: a drain shifts tail into head, then the
    // in-flight word lands in the first free slot after that shift.
    always_comb begin
        head_data_nxt = head_data;
        head_dest_nxt = head_dest;
        tail_data_nxt = tail_data;
        tail_dest_nxt = tail_dest;
        if (drain) begin
            head_data_nxt = tail_data;
            head_dest_nxt = tail_dest;
        end
        if (inflight) begin
            if (count_drained == 2'd0) begin
                head_data_nxt = push_data;
                head_dest_nxt = inflight_dest;
            end else begin
                tail_data_nxt = push_data;
                tail_dest_nxt = inflight_dest;
            end
        end
    end

    assign count_nxt = count_drained + {1'b0, inflight};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight      <= 1'b0;
            inflight_dest <= 1'b0;
            last_grant    <= 1'b1;
            count         <= 2'd0;
            head_data     <= '0;
            head_dest     <= 1'b0;
            tail_data     <= '0;
            tail_dest     <= 1'b0;
            cnt_D0        <= '0;
            cnt_D1        <= '0;
        end else begin
            inflight <= pop_en;
            if (pop_en) begin
                inflight_dest <= grant;
                last_grant    <= grant;
            end
            count     <= count_nxt;
            head_data <= head_data_nxt;
            head_dest <= head_dest_nxt;
            tail_data <= tail_data_nxt;
            tail_dest <= tail_dest_nxt;
            if (drain) begin
                if (head_dest) begin
                    cnt_D1 <= cnt_D1 + 1'b1;
                end else begin
                    cnt_D0 <= cnt_D0 + 1'b1;
                end
            end
        end
    end

    assign bus.valid_out = (count != 2'd0);
    assign bus.data_out  = head_data;
    assign bus.dest_out  = head_dest;
endmodule

// File: tb/tb_dest_output_arbiter.sv
// tb/tb_dest_output_arbiter.sv - self-checking bench for dest_output_arbiter
module tb_dest_output_arbiter;
    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          active_in = 1'b0;
    logic [CW-1:0] cnt_D0;
    logic [CW-1:0] cnt_D1;

    dest_output_arbiter_if #(.data_width(DW)) bus ();

    dest_output_arbiter #(.data_width(DW), .cnt_width(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .active_in (active_in),
        .bus       (bus.slave),
        .cnt_D0    (cnt_D0),
        .cnt_D1    (cnt_D1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dest;
        logic [DW-1:0] data;
        int            t;
    } item_t;

    typedef struct {
        logic rdy;
        logic act;
        logic p0;
        logic p1;
        logic valid;
        logic dest;
    } vec_t;

    item_t         exp_q[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          m_last = 1'b1;
    int            m_cnt0 = 0;
    int            m_cnt1 = 0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            n_pops = 0;
    int            n_drains = 0;
    logic          s_p0, s_p1, s_valid, s_dest;
    logic [DW-1:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, sample/compare after settling, FIFO model reacts just after posedge.
    task automatic tick(input logic rdy, input logic act);
        logic e0, e1, ev, ed, ep, g;
        int   pend;
        @(negedge clk);
        bus.out_ready     = rdy;
        active_in         = act;
        bus.empty_fifo_D0 = (q0.size() == 0);
        bus.empty_fifo_D1 = (q1.size() == 0);
        #1;
        s_p0    = bus.D0_pop;
        s_p1    = bus.D1_pop;
        s_valid = bus.valid_out;
        s_data  = bus.data_out;
        s_dest  = bus.dest_out;
        if (!reset) begin
            exp_q.delete();
            m_last = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
            chk("rst_pop0", s_p0, 0);
            chk("rst_pop1", s_p1, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_data", s_data, 0);
            chk("rst_dest", s_dest, 0);
            chk("rst_cnt0", cnt_D0, 0);
            chk("rst_cnt1", cnt_D1, 0);
        end else begin
            e0   = (q0.size() == 0);
            e1   = (q1.size() == 0);
            ev   = (exp_q.size() > 0) && (exp_q[0].t <= cyc - 2);
            ed   = ev && rdy;
            pend = exp_q.size() - (ed ? 1 : 0);
            g    = (!e0 && !e1) ? ~m_last : e0;
            ep   = act && (!e0 || !e1) && (pend <= 1);
            chk("valid_out", s_valid, ev);
            if (ev) begin
                chk("data_out", s_data, exp_q[0].data);
                chk("dest_out", s_dest, exp_q[0].dest);
            end
            chk("D0_pop", s_p0, ep && !g);
            chk("D1_pop", s_p1, ep && g);
            chk("cnt_D0", cnt_D0, m_cnt0 % (1 << CW));
            chk("cnt_D1", cnt_D1, m_cnt1 % (1 << CW));
            if (ed) begin
                if (exp_q[0].dest) m_cnt1++;
                else m_cnt0++;
                void'(exp_q.pop_front());
                n_drains++;
            end
            if (ep) begin
                exp_q.push_back('{dest: g, data: (g ? q1[0] : q0[0]), t: cyc});
                m_last = g;
            end
        end
        if (s_p0 || s_p1) n_pops++;
        @(posedge clk);
        #1;
        if (s_p0 && q0.size() > 0) bus.data_out_D0 = q0.pop_front();
        if (s_p1 && q1.size() > 0) bus.data_out_D1 = q1.pop_front();
        bus.empty_fifo_D0 = (q0.size() == 0);
        bus.empty_fifo_D1 = (q1.size() == 0);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        reset = 1'b1;
    endtask

    vec_t          vt[12];
    logic [5:0]    pb;
    logic [DW-1:0] first_word;
    logic          seen;

    initial begin
        bus.out_ready     = 1'b0;
        bus.empty_fifo_D0 = 1'b1;
        bus.empty_fifo_D1 = 1'b1;
        bus.data_out_D0   = '0;
        bus.data_out_D1   = '0;

        for (int i = 0; i < 12; i++) begin
            vt[i].rdy   = 1'b1;
            vt[i].act   = 1'b1;
            vt[i].p0    = (i < 8) && (i % 2 == 0);
            vt[i].p1    = (i < 8) && (i % 2 == 1);
            vt[i].valid = (i >= 2) && (i < 10);
            vt[i].dest  = (i >= 2) ? 1'((i - 2) % 2) : 1'b0;
        end

        #2 reset = 1'b0;

        // reset hold with both FIFOs loaded, then round-robin table from release
        for (int i = 0; i < 4; i++) begin
            q0.push_back(6'(8'h10 + i));
            q1.push_back(6'(8'h20 + i));
        end
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(vt[i].rdy, vt[i].act);
            chk("rr_pop0", s_p0, vt[i].p0);
            chk("rr_pop1", s_p1, vt[i].p1);
            chk("rr_valid", s_valid, vt[i].valid);
            if (vt[i].valid) chk("rr_dest", s_dest, vt[i].dest);
        end
        chk("rr_cnt0", cnt_D0, 4);
        chk("rr_cnt1", cnt_D1, 4);

        // single stream from D0
        do_reset();
        q0.push_back(6'b110100);
        q0.push_back(6'b110101);
        q0.push_back(6'b110110);
        pb = '0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            pb[i] = s_p0;
            if (i == 2) chk("single_first", s_data, 6'b110100);
            if (i == 4) chk("single_last", s_data, 6'b110110);
        end
        chk("single_pops", pb, 6'b000111);
        chk("single_cnt0", cnt_D0, 3);

        // backpressure: only two words taken while out_ready is low
        do_reset();
        for (int i = 1; i <= 5; i++) q0.push_back(6'(i + 8'h30));
        n_pops = 0;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        chk("bp_pops", n_pops, 2);
        chk("bp_valid", s_valid, 1);
        chk("bp_hold", s_data, 6'h31);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        chk("bp_cnt0", cnt_D0, 5);
        chk("bp_left", q0.size(), 0);

        // active_in dropped right after one pop
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back(6'(i + 8'h05));
        n_pops = 0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("act_pops", n_pops, 1);
        chk("act_cnt0", cnt_D0, 1);
        chk("act_left", q0.size(), 2);
        q0.delete();

        // counter wrap on D1
        do_reset();
        for (int i = 0; i < 256; i++) q1.push_back(6'($urandom));
        n_drains = 0;
        for (int i = 0; i < 262; i++) tick(1'b1, 1'b1);
        chk("wrap_drains", n_drains, 256);
        chk("wrap_cnt1", cnt_D1, 0);
        chk("wrap_cnt0", cnt_D0, 0);

        // reset while the buffer is full
        do_reset();
        q0.push_back(6'h0a);
        q0.push_back(6'h0b);
        q0.push_back(6'h0c);
        q0.push_back(6'h0d);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        chk("mid_full", s_valid, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_async_valid", bus.valid_out, 0);
        tick(1'b0, 1'b1);
        reset = 1'b1;
        seen = 1'b0;
        first_word = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            if (!seen && s_valid) begin
                seen = 1'b1;
                first_word = s_data;
            end
        end
        chk("mid_seen", seen, 1);
        chk("mid_first", first_word, 6'h0c);
        chk("mid_cnt0", cnt_D0, 2);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 3 == 0) && q0.size() < 6) q0.push_back(6'($urandom));
            if (($urandom % 3 == 0) && q1.size() < 6) q1.push_back(6'($urandom));
            tick(($urandom % 4) != 0, ($urandom % 8) != 0);
        end
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b1);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_fifos", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
